// File: rtl/gray_mon_pkg.sv
// Shared types and defaults for the Gray-code sequence monitor.
package gray_mon_pkg;

  // Default Gray/binary code width and error-counter width
  localparam int DEF_W  = 4;
  localparam int DEF_EW = 8;

  // Monitor FSM: waiting for the first sample, acquiring a direction, tracking
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Classification of one sample against the previous one
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    BAD  = 2'd3
  } step_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Binary bit i is the XOR of all Gray bits from i up to the MSB
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^(i_gray >> i);
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// Watches a Gray-coded counter, locks onto its count direction and flags
// illegal transitions, keeping a saturating count of them.
module gray_seq_monitor
  import gray_mon_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int EW = DEF_EW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [W-1:0]  GIN,
  input  logic          CLR_ERR,
  output logic [W-1:0]  BIN,
  output logic          DIR,
  output logic          LOCKED,
  output logic          STEP,
  output logic          WRAP,
  output logic          ERR,
  output logic [EW-1:0] ERR_CNT
);

  localparam logic [W-1:0]  BIN_MAX = {W{1'b1}};
  localparam logic [EW-1:0] CNT_MAX = {EW{1'b1}};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ONE_EW  = {{(EW-1){1'b0}}, 1'b1};

  state_t      r_state, w_state_nxt;
  step_t       w_cls;
  logic [W-1:0] w_new_bin;
  logic [W-1:0] w_diff;
  logic [W-1:0] r_bin;        // last sampled binary value; also serves as prev_bin
  logic        r_dir, w_dir_nxt;
  logic        r_step, r_wrap, r_err;
  logic        w_step_nxt, w_wrap_nxt, w_err_nxt;
  logic        w_bin_upd;
  logic        w_cross;
  logic [EW-1:0] r_err_cnt;

  gray2bin #(.W(W)) u_gray2bin (
    .i_gray (GIN),
    .o_bin  (w_new_bin)
  );

  assign w_diff = w_new_bin - r_bin;

  // Classify the modular distance between the new and previous value
  always_comb begin
    w_cls = BAD;
    if (w_diff == '0)
      w_cls = HOLD;
    else if (w_diff == ONE_W)
      w_cls = UP;
    else if (w_diff == BIN_MAX)
      w_cls = DOWN;
  end

  // A valid step crosses the boundary when it leaves 2^W-1 upward or 0 downward
  assign w_cross = ((w_cls == UP) && (r_bin == BIN_MAX)) ||
                   ((w_cls == DOWN) && (r_bin == '0));

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state, direction and pulse decode for the current sample
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_bin_upd   = 1'b0;
    if (EN) begin
      w_bin_upd = 1'b1;
      case (r_state)
        IDLE: begin
          w_state_nxt = ACQ;
        end
        ACQ: begin
          case (w_cls)
            HOLD: ;
            UP, DOWN: begin
              w_dir_nxt   = (w_cls == DOWN);
              w_step_nxt  = 1'b1;
              w_wrap_nxt  = w_cross;
              w_state_nxt = TRACK;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
        TRACK: begin
          case (w_cls)
            HOLD: ;
            UP, DOWN: begin
              // A step against the locked direction means the lock was wrong
              if ((w_cls == DOWN) == r_dir) begin
                w_step_nxt = 1'b1;
                w_wrap_nxt = w_cross;
              end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ACQ;
              end
            end
            default: begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ACQ;
            end
          endcase
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Sampled value, direction and one-cycle pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bin  <= '0;
      r_dir  <= 1'b1;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_bin_upd)
        r_bin <= w_new_bin;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
      r_wrap <= w_wrap_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Saturating error counter; a clear that coincides with a new error leaves 1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_err_cnt <= '0;
    else if (CLR_ERR)
      r_err_cnt <= w_err_nxt ? ONE_EW : '0;
    else if (w_err_nxt && (r_err_cnt != CNT_MAX))
      r_err_cnt <= r_err_cnt + ONE_EW;
  end

  assign BIN     = r_bin;
  assign DIR     = r_dir;
  assign LOCKED  = (r_state == TRACK);
  assign STEP    = r_step;
  assign WRAP    = r_wrap;
  assign ERR     = r_err;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Directed self-checking bench for gray_seq_monitor (W=4, EW=8).
module tb_gray_seq_monitor;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [3:0] GIN;
  logic       CLR_ERR;
  logic [3:0] BIN;
  logic       DIR;
  logic       LOCKED;
  logic       STEP;
  logic       WRAP;
  logic       ERR;
  logic [7:0] ERR_CNT;

  int n_checks = 0;
  int n_errors = 0;

  gray_seq_monitor #(.W(4), .EW(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .GIN     (GIN),
    .CLR_ERR (CLR_ERR),
    .BIN     (BIN),
    .DIR     (DIR),
    .LOCKED  (LOCKED),
    .STEP    (STEP),
    .WRAP    (WRAP),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample and return 1 time unit after the capturing edge
  task automatic drive(input logic en, input logic [3:0] g);
    EN  = en;
    GIN = g;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bin"},    BIN, 0);
    check({tag, "_dir"},    DIR, 1);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_step"},   STEP, 0);
    check({tag, "_wrap"},   WRAP, 0);
    check({tag, "_err"},    ERR, 0);
    check({tag, "_cnt"},    ERR_CNT, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; EN = 1'b0; GIN = 4'b0000; CLR_ERR = 1'b0;
    #12;
    check_reset_vals("rst0");
    RST = 1'b1;

    // Lock on a down count 15,14,13,12
    drive(1, 4'b1000);
    check("acq_bin", BIN, 15);   check("acq_step", STEP, 0);
    check("acq_lock", LOCKED, 0); check("acq_err", ERR, 0);
    drive(1, 4'b1001);
    check("dn1_bin", BIN, 14);   check("dn1_step", STEP, 1);
    check("dn1_lock", LOCKED, 1); check("dn1_dir", DIR, 1);
    drive(1, 4'b1011);
    check("dn2_bin", BIN, 13);   check("dn2_step", STEP, 1);
    drive(1, 4'b1010);
    check("dn3_bin", BIN, 12);   check("dn3_step", STEP, 1);
    check("dn3_cnt", ERR_CNT, 0); check("dn3_wrap", WRAP, 0);

    // Illegal jump 12 -> 4
    drive(1, 4'b0110);
    check("jmp_err", ERR, 1);    check("jmp_step", STEP, 0);
    check("jmp_lock", LOCKED, 0); check("jmp_cnt", ERR_CNT, 1);
    check("jmp_bin", BIN, 4);

    // 4 -> 6 is another jump, then lock down at 5 and reverse to 6, then 7
    drive(1, 4'b0101);
    check("j2_err", ERR, 1);     check("j2_cnt", ERR_CNT, 2);
    drive(1, 4'b0111);
    check("l5_step", STEP, 1);   check("l5_dir", DIR, 1);
    check("l5_lock", LOCKED, 1); check("l5_err", ERR, 0);
    drive(1, 4'b0101);
    check("rev_err", ERR, 1);    check("rev_step", STEP, 0);
    check("rev_lock", LOCKED, 0); check("rev_cnt", ERR_CNT, 3);
    check("rev_bin", BIN, 6);
    drive(1, 4'b0100);
    check("up7_step", STEP, 1);  check("up7_dir", DIR, 0);
    check("up7_lock", LOCKED, 1); check("up7_bin", BIN, 7);

    // EN gap: nothing moves even though GIN changes
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b0000);
      check("gap_step", STEP, 0); check("gap_err", ERR, 0);
      check("gap_wrap", WRAP, 0); check("gap_bin", BIN, 7);
      check("gap_lock", LOCKED, 1); check("gap_dir", DIR, 0);
    end
    drive(1, 4'b1100);
    check("up8_step", STEP, 1);  check("up8_bin", BIN, 8);
    check("up8_cnt", ERR_CNT, 3);

    // Asynchronous reset between edges
    #3;
    RST = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge CLK);
    RST = 1'b1;

    // Wrap while locked down: 2,1,0,15
    drive(1, 4'b0011);
    check("w_cap_bin", BIN, 2);  check("w_cap_step", STEP, 0);
    check("w_cap_lock", LOCKED, 0);
    drive(1, 4'b0001);
    check("w1_bin", BIN, 1);     check("w1_step", STEP, 1); check("w1_wrap", WRAP, 0);
    drive(1, 4'b0000);
    check("w0_bin", BIN, 0);     check("w0_step", STEP, 1); check("w0_wrap", WRAP, 0);
    drive(1, 4'b1000);
    check("w15_bin", BIN, 15);   check("w15_step", STEP, 1); check("w15_wrap", WRAP, 1);

    // Up wrap 15 -> 0 from ACQ after two bad samples
    drive(1, 4'b0100);
    check("b7_err", ERR, 1);     check("b7_wrap", WRAP, 0); check("b7_bin", BIN, 7);
    drive(1, 4'b1000);
    check("b15_err", ERR, 1);    check("b15_bin", BIN, 15);
    drive(1, 4'b0000);
    check("uw_step", STEP, 1);   check("uw_wrap", WRAP, 1);
    check("uw_dir", DIR, 0);     check("uw_lock", LOCKED, 1);
    check("uw_bin", BIN, 0);     check("uw_cnt", ERR_CNT, 2);
    drive(1, 4'b0000);
    check("hold_step", STEP, 0); check("hold_lock", LOCKED, 1);

    // Saturation and clear
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    drive(1, 4'b0000);
    check("s_cap_err", ERR, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, (i % 2 == 0) ? 4'b1100 : 4'b0000);
      if (i == 9) check("sat_cnt10", ERR_CNT, 10);
      if (i == 0) check("sat_err", ERR, 1);
    end
    check("sat_cnt", ERR_CNT, 255);
    check("sat_step", STEP, 0);
    CLR_ERR = 1'b1;
    drive(1, 4'b1100);
    check("clr_bad_cnt", ERR_CNT, 1);
    check("clr_bad_err", ERR, 1);
    drive(0, 4'b1100);
    check("clr_cnt", ERR_CNT, 0);
    check("clr_err", ERR, 0);
    CLR_ERR = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_seq_monitor.md
GRAY_SEQ_MONITOR -- requirements
Module: gray_seq_monitor

Interface
REQ-001 SHALL have parameter W, default 4, Gray/binary code width.
REQ-002 SHALL have parameter EW, default 8, error-counter width.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 EN  input  1  sample strobe; GIN is evaluated only on cycles with EN=1.
REQ-006 GIN  input  W  Gray code from the upstream Gray counter.
REQ-007 CLR_ERR  input  1  synchronous clear of ERR_CNT.
REQ-008 BIN  output  W  registered binary equivalent of the last sampled GIN.
REQ-009 DIR  output  1  tracked direction: 1 = down (-1 per step), 0 = up (+1 per step).
REQ-010 LOCKED  output  1  high while the FSM is in TRACK.
REQ-011 STEP  output  1  one-cycle pulse for each valid single-count step.
REQ-012 WRAP  output  1  one-cycle pulse on a valid step across the 0 / 2^W-1 boundary.
REQ-013 ERR  output  1  one-cycle pulse for each illegal transition.
REQ-014 ERR_CNT  output  EW  saturating count of ERR pulses.

Function
REQ-015 Binary conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
REQ-016 The block SHALL keep prev_bin, the binary of the last sampled code.
- Per sample: diff = (new_bin - prev_bin) mod 2^W.
- diff=0 is HOLD; diff=1 is UP; diff=2^W-1 is DOWN; any other value is BAD.
REQ-017 FSM states: IDLE, ACQ, TRACK.
REQ-018 IDLE, EN=1:
- Capture prev_bin and BIN.
- Go to ACQ.
- No STEP, WRAP or ERR.
REQ-019 ACQ, EN=1:
- HOLD: stay in ACQ.
- UP/DOWN: set DIR (UP→0, DOWN→1), pulse STEP, pulse WRAP if the boundary is crossed, go to TRACK.
- BAD: pulse ERR, stay in ACQ.
REQ-020 TRACK, EN=1:
- HOLD: stay in TRACK, no pulse.
- Step matching DIR: pulse STEP, pulse WRAP if the boundary is crossed.
- Step opposite to DIR: pulse ERR, go to ACQ.
- BAD: pulse ERR, go to ACQ.
REQ-021 On every EN=1 sample outside IDLE, prev_bin and BIN SHALL update to the new value, including HOLD and error samples.
REQ-022 With EN=0:
- State, BIN, prev_bin and DIR hold.
- STEP, WRAP and ERR are 0.
REQ-023 Latency: BIN, STEP, WRAP, ERR, LOCKED and DIR reflect a sample at rising edge n and are visible after edge n (registered, one cycle).
REQ-024 WRAP conditions (W=4):
- DOWN with prev_bin=0 and new_bin=15.
- UP with prev_bin=15 and new_bin=0.
- WRAP is asserted only together with STEP.
REQ-025 ERR_CNT update:
- Increments on each ERR pulse.
- Saturates at 2^EW-1.
- CLR_ERR alone sets it to 0.
- CLR_ERR coincident with an ERR pulse sets it to 1.
REQ-026 STEP and ERR SHALL never be high in the same cycle.

Reset
REQ-027 While RST=0, regardless of CLK:
- State = IDLE.
- BIN = 0, prev_bin = 0.
- DIR = 1.
- LOCKED = 0, STEP = 0, WRAP = 0, ERR = 0.
- ERR_CNT = 0.
REQ-028 Reset asserted mid-operation SHALL discard lock and direction; the first EN sample after release is treated per REQ-018.

Structure
REQ-029 Package gray_mon_pkg SHALL hold:
- FSM state enum (IDLE, ACQ, TRACK).
- Default W and EW constants.
- Step-class enum (HOLD, UP, DOWN, BAD).
REQ-030 Combinational sub-module gray2bin (parameter W) SHALL implement REQ-015; it is the only sub-module.

Verification
REQ-031 Lock on a down count:
- Stimulus: reset; EN=1 each cycle; GIN = 1000, 1001, 1011, 1010 (binary 15,14,13,12).
- Response: first sample gives no pulse; then STEP=1 on three samples; LOCKED=1 from the second sample; DIR=1; ERR_CNT=0.
REQ-032 Wrap:
- Stimulus: while locked down, GIN 0001→0000→1000.
- Response: BIN 1→0→15; STEP on both steps; WRAP=1 only on 0→15.
REQ-033 Illegal jump:
- Stimulus: locked, BIN=12, GIN jumps to 0110 (4).
- Response: ERR=1, STEP=0, LOCKED=0 next cycle, ERR_CNT=1, BIN=4.
REQ-034 Reversal:
- Stimulus: locked down at 5, then GIN for 6.
- Response: ERR pulse, return to ACQ; the following step to 7 gives STEP, DIR=0, LOCKED=1.
REQ-035 Saturation and clear:
- Stimulus: 300 BAD samples (EW=8).
- Response: ERR_CNT holds at 255; CLR_ERR with a coincident BAD sample gives 1; CLR_ERR alone gives 0.
REQ-036 EN gaps and reset:
- Stimulus: EN=0 for 5 cycles mid-track, then RST=0 asynchronously between edges.
- Response: no pulses and no change during EN=0; all outputs are at reset values immediately on RST=0.
